xor2_unit: RTL and testbench
============================

// Module: xor2_unit
// PURPOSE
//  Two-input XOR primitive from the basic-gates library. x is the purely
//  combinational bitwise XOR of a and b. The block also carries a registered
//  copy (x_q) and its parity, so downstream clocked logic can use the result
//  without adding its own flop stage. Used as a leaf cell in datapath and
//  parity logic.
// PARAMETERS
//  WIDTH  1  bit width of a, b, x and x_q. Legal values are 1 to 64.
// PORTS
//  clk     in   1      single clock; all flops update on the rising edge
//  rst     in   1      asynchronous, active-high reset
//  a       in   WIDTH  operand A
//  b       in   WIDTH  operand B
//  en      in   1      capture enable for the registered path
//  x       out  WIDTH  a ^ b, combinational, zero latency
//  x_q     out  WIDTH  registered a ^ b
//  par_q   out  1      registered reduction XOR of (a ^ b)
//  vld_q   out  1      high when x_q and par_q hold a captured result
// BEHAVIOUR
//  - One clock domain (clk). Reset is asynchronous and active-high; rst
//    clears all flops immediately, independent of clk.
//  - x = a ^ b, bit by bit. It is combinational at all times, so it does not
//    depend on clk, rst or en, and is valid even while rst is high.
//  - Truth table per bit: 00->0, 10->1, 01->1, 11->0.
//  - Reset values: x_q = 0, par_q = 0, vld_q = 0.
//  - Rising clk edge with rst low and en high: x_q <= a ^ b,
//    par_q <= ^(a ^ b), vld_q <= 1. Latency is one cycle.
//  - Rising clk edge with rst low and en low: x_q and par_q hold their values;
//    vld_q <= 0.
//  - Reset asserted mid-operation: the registered outputs clear at once; x
//    keeps tracking its inputs. The first capture after rst deasserts happens
//    on the first rising edge where en is high.
//  - Width rules: all data widths are WIDTH with no extension or truncation.
//    par_q is always 1 bit.
//  - The block has no handshake and no back-pressure; en is a plain strobe.
//  - X or Z on an input propagates to x. The design must not mask it.
// STRUCTURE
//  - Shared package gates_pkg: localparam XOR2_DEFAULT_WIDTH = 1, and
//    localparam XOR2_MAX_WIDTH = 64 for parameter range checks.
//  - One sub-module, xor2_bit: a 1-bit combinational XOR. It is instantiated
//    WIDTH times through a generate loop to form x.
//  - Top level holds the x_q/par_q/vld_q register stage, the reduction XOR,
//    and an elaboration-time check that 1 <= WIDTH <= XOR2_MAX_WIDTH.
// TESTING
//  1. WIDTH=1 combinational sweep: (a,b) = 00, 10, 01, 11, each held 100 ns
//     with no clocking. Expect x = 0, 1, 1, 0, settled within each interval.
//  2. Registered path: apply a=1, b=0, en=1, then clock once.
//     Expect x_q=1, par_q=1, vld_q=1 after the edge, and 0/0/0 before it.
//  3. Enable hold: with x_q=1, set a=1, b=1, en=0, then clock twice.
//     Expect x_q stays 1 and vld_q=0, while x=0 immediately.
//  4. Async reset: pulse rst between clock edges while x_q=1.
//     Expect x_q, par_q and vld_q = 0 immediately with no edge, and x
//     unaffected.
//  5. WIDTH=8: a=8'hA5, b=8'h0F, en=1, clock once.
//     Expect x=8'hAA, x_q=8'hAA, par_q=0.
//     Then a=8'hFF, b=8'h01: expect x_q=8'hFE, par_q=1.
//  6. Back-to-back captures: en held high, four cycles of the sweep in (1).
//     Expect x_q to follow x delayed by one cycle and vld_q=1 throughout.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared constants for the basic-gates library cells.
package gates_pkg;

   localparam int XOR2_DEFAULT_WIDTH = 1;
   localparam int XOR2_MAX_WIDTH     = 64;

endpackage : gates_pkg

// File: rtl/xor2_bit.sv
// Single-bit combinational XOR leaf; X/Z on an input propagates to the output.
module xor2_bit (
   input  logic i_a,
   input  logic i_b,
   output logic o_x
);

   assign o_x = i_a ^ i_b;

endmodule : xor2_bit

// File: rtl/xor2_unit.sv
// WIDTH-bit XOR with a zero-latency combinational output plus a registered
// copy, its parity and a valid flag for downstream clocked logic.
module xor2_unit
   import gates_pkg::*;
#(
   parameter int WIDTH = XOR2_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] x_q,
   output logic             par_q,
   output logic             vld_q
);

   logic [WIDTH-1:0] w_x;
   logic             w_par;
   logic [WIDTH-1:0] r_x_q;
   logic             r_par_q;
   logic             r_vld_q;

   if (WIDTH < 1 || WIDTH > XOR2_MAX_WIDTH) begin : g_width_check
      $error("xor2_unit: WIDTH must be between 1 and XOR2_MAX_WIDTH");
   end

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      xor2_bit u_bit (
         .i_a (a[gi]),
         .i_b (b[gi]),
         .o_x (w_x[gi])
      );
   end

   assign w_par = ^w_x;

   // Data and parity hold while en is low; only the valid flag drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x_q   <= '0;
         r_par_q <= 1'b0;
         r_vld_q <= 1'b0;
      end else if (en) begin
         r_x_q   <= w_x;
         r_par_q <= w_par;
         r_vld_q <= 1'b1;
      end else begin
         r_vld_q <= 1'b0;
      end
   end

   assign x     = w_x;
   assign x_q   = r_x_q;
   assign par_q = r_par_q;
   assign vld_q = r_vld_q;

endmodule : xor2_unit

// File: tb/tb_xor2_unit.sv
// Scoreboard bench for xor2_unit: 1-bit and 8-bit instances share clk/rst/en.
module tb_xor2_unit;

   typedef struct {
      logic [7:0] xq8;
      logic       pq8;
      logic       vq8;
      logic       xq1;
      logic       pq1;
      logic       vq1;
   } exp_t;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, x8, xq8;
   logic       pq8, vq8;
   logic       a1 = 1'b0, b1 = 1'b0, x1, xq1;
   logic       pq1, vq1;

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;

   exp_t exp_q[$];
   exp_t mon_e;

   // Behavioural model: last captured result and valid flag per instance
   logic [7:0] m8_xq = '0;
   logic       m8_pq = 1'b0, m8_vq = 1'b0;
   logic       m1_xq = 1'b0, m1_pq = 1'b0, m1_vq = 1'b0;

   // Per-bit truth table for (a,b) = 00,10,01,11
   logic [3:0] tt_a  = 4'b1010;
   logic [3:0] tt_b  = 4'b1100;
   logic [3:0] tt_x  = 4'b0110;

   xor2_unit #(.WIDTH(8)) u8 (
      .clk   (clk),
      .rst   (rst),
      .a     (a8),
      .b     (b8),
      .en    (en),
      .x     (x8),
      .x_q   (xq8),
      .par_q (pq8),
      .vld_q (vq8)
   );

   xor2_unit #(.WIDTH(1)) u1 (
      .clk   (clk),
      .rst   (rst),
      .a     (a1),
      .b     (b1),
      .en    (en),
      .x     (x1),
      .x_q   (xq1),
      .par_q (pq1),
      .vld_q (vq1)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic odd_ones(input logic [7:0] v);
      return ($countones(v) % 2) == 1;
   endfunction

   task automatic model_zero();
      m8_xq = '0; m8_pq = 1'b0; m8_vq = 1'b0;
      m1_xq = 1'b0; m1_pq = 1'b0; m1_vq = 1'b0;
   endtask

   // Predict the state after the coming edge and queue it for the monitor
   task automatic model_edge();
      exp_t e;
      if (rst) begin
         model_zero();
      end else if (en) begin
         m8_xq = a8 ^ b8; m8_pq = odd_ones(a8 ^ b8); m8_vq = 1'b1;
         m1_xq = (a1 != b1); m1_pq = (a1 != b1); m1_vq = 1'b1;
      end else begin
         m8_vq = 1'b0;
         m1_vq = 1'b0;
      end
      e.xq8 = m8_xq; e.pq8 = m8_pq; e.vq8 = m8_vq;
      e.xq1 = m1_xq; e.pq1 = m1_pq; e.vq1 = m1_vq;
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse in the low phase, checked with no clock edge
   task automatic reset_pulse();
      logic [7:0] want_x8;
      want_x8 = a8 ^ b8;
      rst = 1'b1;
      #1;
      chk("arst_xq8", xq8, 0);
      chk("arst_pq8", pq8, 0);
      chk("arst_vq8", vq8, 0);
      chk("arst_xq1", xq1, 0);
      chk("arst_pq1", pq1, 0);
      chk("arst_vq1", vq1, 0);
      chk("arst_x8", x8, want_x8);
      chk("arst_x1", x1, a1 != b1);
      #1;
      rst = 1'b0;
      model_zero();
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_txn++;
         $display("txn %0d: x_q8=%02h par8=%0b vld8=%0b x_q1=%0b par1=%0b vld1=%0b",
                  n_txn, xq8, pq8, vq8, xq1, pq1, vq1);
         chk("mon_xq8", xq8, mon_e.xq8);
         chk("mon_pq8", pq8, mon_e.pq8);
         chk("mon_vq8", vq8, mon_e.vq8);
         chk("mon_xq1", xq1, mon_e.xq1);
         chk("mon_pq1", pq1, mon_e.pq1);
         chk("mon_vq1", vq1, mon_e.vq1);
      end
   end

   initial begin
      #1;
      chk("rst_xq8", xq8, 0);
      chk("rst_pq8", pq8, 0);
      chk("rst_vq8", vq8, 0);
      chk("rst_xq1", xq1, 0);
      chk("rst_vq1", vq1, 0);

      // Combinational sweep with the clock stopped and rst still high
      for (int i = 0; i < 4; i++) begin
         a1 = tt_a[i];
         b1 = tt_b[i];
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         #100;
         chk("sweep_x1", x1, tt_x[i]);
         chk("sweep_x8", x8, a8 ^ b8);
      end

      clk_run = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // First capture and the 8-bit A5^0F case
      a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h0F; en = 1'b1;
      #1;
      chk("pre_xq1", xq1, 0);
      chk("pre_pq1", pq1, 0);
      chk("pre_vq1", vq1, 0);
      chk("x8_aa", x8, 8'hAA);
      cycle();
      chk("cap_xq1", xq1, 1);
      chk("cap_xq8", xq8, 8'hAA);
      chk("cap_pq8", pq8, 0);

      // Enable low: data holds, valid drops, x follows immediately
      a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'h01; en = 1'b0;
      #1;
      chk("hold_x1", x1, 0);
      chk("hold_x8", x8, 8'hFE);
      cycle();
      cycle();
      chk("hold_xq1", xq1, 1);
      chk("hold_vq1", vq1, 0);

      reset_pulse();

      en = 1'b1;
      cycle();
      chk("fe_xq8", xq8, 8'hFE);
      chk("fe_pq8", pq8, 1);

      // Back-to-back captures over the truth-table sweep
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i];
            b1 = tt_b[i];
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            #1;
            chk("b2b_x1", x1, tt_x[i]);
            cycle();
         end
      end

      // Randomized operation with occasional asynchronous resets
      for (int n = 0; n < 200; n++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         a1 = 1'($urandom_range(0, 1));
         b1 = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) reset_pulse();
         #1;
         chk("rnd_x8", x8, a8 ^ b8);
         cycle();
      end

      en = 1'b0;
      cycle();
      chk("drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_xor2_unit
